rdma_sq_arbiter: RTL and testbench

Round-robin arbiter sharing the single RDMA send-queue request path among N_REQ user-side requesters in the user clock domain. Sits upstream of the send-queue clock crossing into the network domain. Stamps each forwarded request with its requester index and, optionally, limits outstanding requests per requester using the returning ack stream.

---
 rtl/rdma_sq_arbiter_pkg.sv | 21 ++
 rtl/rdma_sq_arbiter_rr_pick.sv | 41 ++++
 rtl/rdma_sq_arbiter.sv | 166 ++++++++++++++++
 tb/tb_rdma_sq_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rdma_sq_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lynxTypes (package)
// Brief   : Shared constants and credit-counter type for the RDMA SQ arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package lynxTypes;

    localparam int RDMA_SQ_N_REQ         = 4;
    localparam int RDMA_ACK_ID_LSB       = 0;
    localparam int RDMA_SQ_N_OUTSTANDING = 8;

    // Counter width able to hold 0..n inclusive.
    function automatic int rdma_cred_w(input int n);
        return $clog2(n + 1);
    endfunction

    typedef logic [$clog2(RDMA_SQ_N_OUTSTANDING + 1)-1:0] rdma_sq_cred_t;

endpackage
`default_nettype wire

// File: rtl/rdma_sq_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rdma_rr_pick
// Brief   : Combinational rotating-priority encoder; first set request
//           searching upward from last_i+1, wrapping at N_REQ.
// Revision: 1.0 - initial release
// ============================================================================
module rdma_rr_pick
    import lynxTypes::*;
#(
    parameter int N_REQ = RDMA_SQ_N_REQ
)(
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] last_i,
    output logic                     any_o,
    output logic [$clog2(N_REQ)-1:0] idx_o
);

    localparam int ID_BITS = $clog2(N_REQ);

    logic [ID_BITS:0] pos_w;

    // Walk from the farthest offset down so the nearest hit is written last.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        pos_w = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            pos_w = {1'b0, last_i} + (ID_BITS+1)'(k);
            if (pos_w >= (ID_BITS+1)'(N_REQ)) begin
                pos_w = pos_w - (ID_BITS+1)'(N_REQ);
            end
            if (req_i[pos_w[ID_BITS-1:0]]) begin
                any_o = 1'b1;
                idx_o = pos_w[ID_BITS-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rdma_sq_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rdma_sq_arbiter
// Brief   : Round-robin arbiter onto the RDMA send-queue path with requester
//           id stamping. Define RDMA_SQ_CREDIT_EN to build per-requester
//           outstanding-credit limiting driven by the ack stream.
// Revision: 1.0 - initial release
// ============================================================================
module rdma_sq_arbiter
    import lynxTypes::*;
#(
    parameter int N_REQ         = RDMA_SQ_N_REQ,
    parameter int REQ_BITS      = 256,
    parameter int ACK_BITS      = 40,
    parameter int ACK_ID_LSB    = RDMA_ACK_ID_LSB,
    parameter int N_OUTSTANDING = RDMA_SQ_N_OUTSTANDING
)(
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [N_REQ-1:0]            s_req_valid,
    output logic [N_REQ-1:0]            s_req_ready,
    input  logic [N_REQ*REQ_BITS-1:0]   s_req_data,
    output logic                        m_sq_valid,
    input  logic                        m_sq_ready,
    output logic [REQ_BITS-1:0]         m_sq_data,
    output logic [$clog2(N_REQ)-1:0]    m_sq_id,
    input  logic                        s_ack_valid,
    output logic                        s_ack_ready,
    input  logic [ACK_BITS-1:0]         s_ack_data,
    output logic                        ack_err
);

    localparam int ID_BITS = $clog2(N_REQ);

    logic [N_REQ-1:0]    eligible_w;
    logic                pick_any_w;
    logic [ID_BITS-1:0]  pick_idx_w;
    logic                free_w;
    logic                grant_w;
    logic [REQ_BITS-1:0] req_data_w [N_REQ];
    logic                ack_unused_w;

    logic                m_valid_q, m_valid_d;
    logic [REQ_BITS-1:0] m_data_q,  m_data_d;
    logic [ID_BITS-1:0]  m_id_q,    m_id_d;
    logic [ID_BITS-1:0]  last_q,    last_d;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign req_data_w[i] = s_req_data[i*REQ_BITS +: REQ_BITS];
    end

    rdma_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i  (eligible_w),
        .last_i (last_q),
        .any_o  (pick_any_w),
        .idx_o  (pick_idx_w)
    );

    // Reset also masks ready so nothing is accepted while state is cleared.
    assign free_w  = !m_valid_q || m_sq_ready;
    assign grant_w = free_w && pick_any_w && !areset;

    always_comb begin
        s_req_ready = '0;
        if (grant_w) begin
            s_req_ready[pick_idx_w] = 1'b1;
        end
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_id_d    = m_id_q;
        last_d    = last_q;
        if (grant_w) begin
            m_valid_d = 1'b1;
            m_data_d  = req_data_w[pick_idx_w];
            m_id_d    = pick_idx_w;
            last_d    = pick_idx_w;
        end else if (m_sq_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_id_q    <= '0;
            last_q    <= ID_BITS'(N_REQ - 1);
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_id_q    <= m_id_d;
            last_q    <= last_d;
        end
    end

    assign m_sq_valid   = m_valid_q;
    assign m_sq_data    = m_data_q;
    assign m_sq_id      = m_id_q;
    assign s_ack_ready  = 1'b1;
    assign ack_unused_w = ^{s_ack_valid, s_ack_data};

`ifdef RDMA_SQ_CREDIT_EN
    localparam int CRED_W = rdma_cred_w(N_OUTSTANDING);

    logic [ID_BITS-1:0] ack_id_w;
    logic               ack_in_range_w;
    logic [N_REQ-1:0]   zero_ack_w;
    logic               ack_err_q, ack_err_d;

    assign ack_id_w       = s_ack_data[ACK_ID_LSB +: ID_BITS];
    assign ack_in_range_w = ({1'b0, ack_id_w} < (ID_BITS+1)'(N_REQ));

    for (genvar i = 0; i < N_REQ; i++) begin : g_cred
        logic [CRED_W-1:0] cred_q, cred_d;
        logic              inc_w, dec_w;

        assign inc_w = grant_w && (pick_idx_w == ID_BITS'(i));
        assign dec_w = s_ack_valid && ack_in_range_w && (ack_id_w == ID_BITS'(i));

        // Eligibility uses only registered credit, so acks never reach ready combinationally.
        assign eligible_w[i] = s_req_valid[i] && (cred_q < CRED_W'(N_OUTSTANDING));
        assign zero_ack_w[i] = dec_w && !inc_w && (cred_q == '0);

        always_comb begin
            cred_d = cred_q;
            if (inc_w && !dec_w) begin
                cred_d = cred_q + CRED_W'(1);
            end else if (dec_w && !inc_w && (cred_q != '0)) begin
                cred_d = cred_q - CRED_W'(1);
            end
        end

        always_ff @(posedge aclk) begin
            if (areset) begin
                cred_q <= '0;
            end else begin
                cred_q <= cred_d;
            end
        end
    end

    assign ack_err_d = ack_err_q
                     | (s_ack_valid && !ack_in_range_w)
                     | (|zero_ack_w);

    always_ff @(posedge aclk) begin
        if (areset) begin
            ack_err_q <= 1'b0;
        end else begin
            ack_err_q <= ack_err_d;
        end
    end

    assign ack_err = ack_err_q;
`else
    assign eligible_w = s_req_valid;
    assign ack_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rdma_sq_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_rdma_sq_arbiter
// Brief   : Self-checking bench for rdma_sq_arbiter against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rdma_sq_arbiter;

    localparam int N       = 4;
    localparam int RB      = 32;
    localparam int AB      = 40;
    localparam int ALSB    = 3;
    localparam int NOUT    = 2;

    logic            aclk = 1'b0;
    logic            areset;
    logic [N-1:0]    s_req_valid;
    logic [N-1:0]    s_req_ready;
    logic [N*RB-1:0] s_req_data;
    logic            m_sq_valid;
    logic            m_sq_ready;
    logic [RB-1:0]   m_sq_data;
    logic [1:0]      m_sq_id;
    logic            s_ack_valid;
    logic            s_ack_ready;
    logic [AB-1:0]   s_ack_data;
    logic            ack_err;

    always #5 aclk = ~aclk;

    rdma_sq_arbiter #(
        .N_REQ         (N),
        .REQ_BITS      (RB),
        .ACK_BITS      (AB),
        .ACK_ID_LSB    (ALSB),
        .N_OUTSTANDING (NOUT)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .s_req_valid (s_req_valid),
        .s_req_ready (s_req_ready),
        .s_req_data  (s_req_data),
        .m_sq_valid  (m_sq_valid),
        .m_sq_ready  (m_sq_ready),
        .m_sq_data   (m_sq_data),
        .m_sq_id     (m_sq_id),
        .s_ack_valid (s_ack_valid),
        .s_ack_ready (s_ack_ready),
        .s_ack_data  (s_ack_data),
        .ack_err     (ack_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit            mdl_valid;
    logic [RB-1:0] mdl_data;
    int            mdl_id;
    int            mdl_last;
    int            mdl_cred [N];
    bit            mdl_err;
    bit            mdl_after_rst;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit may_issue(input int idx);
`ifdef RDMA_SQ_CREDIT_EN
        return mdl_cred[idx] < NOUT;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        mdl_valid     = 1'b0;
        mdl_data      = '0;
        mdl_id        = 0;
        mdl_last      = N - 1;
        mdl_err       = 1'b0;
        mdl_after_rst = 1'b1;
        for (int i = 0; i < N; i++) mdl_cred[i] = 0;
    endtask

    // One clock cycle: drive, check the grant, advance, check the output register.
    task automatic step(input logic [N-1:0] v, input logic rdy, input logic av,
                        input int aid, input logic rst_in);
        int   g;
        logic [N-1:0] exp_rdy;
        @(negedge aclk);
        areset      = rst_in;
        s_req_valid = v;
        m_sq_ready  = rdy;
        s_ack_valid = av;
        s_ack_data  = AB'({$urandom, $urandom});
        s_ack_data[ALSB +: 2] = 2'(aid);
        for (int i = 0; i < N; i++) s_req_data[i*RB +: RB] = $urandom;
        #1;
        g = -1;
        if (!rst_in && (!mdl_valid || rdy)) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (mdl_last + k) % N;
                if (g < 0 && v[idx] && may_issue(idx)) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check_val("req_ready", 64'(s_req_ready), 64'(exp_rdy));
        check_val("ack_ready", 64'(s_ack_ready), 64'd1);

        if (rst_in) begin
            model_reset();
        end else begin
            mdl_after_rst = 1'b0;
`ifdef RDMA_SQ_CREDIT_EN
            for (int i = 0; i < N; i++) begin
                bit inc, dec;
                inc = (g == i);
                dec = av && (aid == i);
                if (inc && !dec) mdl_cred[i]++;
                else if (dec && !inc) begin
                    if (mdl_cred[i] == 0) mdl_err = 1'b1;
                    else mdl_cred[i]--;
                end
            end
            if (av && aid >= N) mdl_err = 1'b1;
`endif
            if (g >= 0) begin
                mdl_valid = 1'b1;
                mdl_data  = s_req_data[g*RB +: RB];
                mdl_id    = g;
                mdl_last  = g;
            end else if (rdy) begin
                mdl_valid = 1'b0;
            end
        end

        @(posedge aclk);
        #1;
        check_val("sq_valid", 64'(m_sq_valid), 64'(mdl_valid));
        if (mdl_valid || mdl_after_rst) begin
            check_val("sq_data", 64'(m_sq_data), 64'(mdl_data));
            check_val("sq_id", 64'(m_sq_id), 64'(mdl_id));
        end
        check_val("ack_err", 64'(ack_err), 64'(mdl_err));
    endtask

    logic [RB-1:0] saved;
    int            seq [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        areset = 1'b1; s_req_valid = '0; m_sq_ready = 1'b0;
        s_req_data = '0; s_ack_valid = 1'b0; s_ack_data = '0;
        model_reset();
        step(4'b1111, 1'b1, 1'b0, 0, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 0, 1'b1);
        check_val("rst_valid", 64'(m_sq_valid), 64'd0);

        // Single requester streaming three requests
        for (int t = 0; t < 3; t++) begin
            step(4'b0001, 1'b1, (t > 0), 0, 1'b0);
            check_val("t1_valid", 64'(m_sq_valid), 64'd1);
            check_val("t1_id", 64'(m_sq_id), 64'd0);
        end
        step(4'b0000, 1'b1, 1'b0, 0, 1'b0);

        // Round-robin order with everyone requesting
        step(4'b0000, 1'b0, 1'b0, 0, 1'b1);
        for (int t = 0; t < 6; t++) begin
            step(4'b1111, 1'b1, 1'b0, 0, 1'b0);
            check_val("rr_seq", 64'(m_sq_id), 64'(seq[t]));
        end

        // Backpressure hold and fair release
        step(4'b0000, 1'b0, 1'b0, 0, 1'b1);
        step(4'b0110, 1'b1, 1'b0, 0, 1'b0);
        saved = m_sq_data;
        for (int t = 0; t < 5; t++) begin
            step(4'b1111, 1'b0, 1'b0, 0, 1'b0);
            check_val("hold_data", 64'(m_sq_data), 64'(saved));
            check_val("hold_id", 64'(m_sq_id), 64'd1);
            check_val("hold_ready", 64'(s_req_ready), 64'd0);
        end
        step(4'b1111, 1'b1, 1'b0, 0, 1'b0);
        check_val("release_id", 64'(m_sq_id), 64'd2);

        // Credit exhaustion and ack-driven release
        step(4'b0000, 1'b0, 1'b0, 0, 1'b1);
        for (int t = 0; t < 3; t++) step(4'b0010, 1'b1, 1'b0, 0, 1'b0);
`ifdef RDMA_SQ_CREDIT_EN
        check_val("stall_valid", 64'(m_sq_valid), 64'd0);
`endif
        step(4'b0010, 1'b1, 1'b1, 1, 1'b0);
        step(4'b0010, 1'b1, 1'b0, 0, 1'b0);
        check_val("ack_release_valid", 64'(m_sq_valid), 64'd1);
        check_val("ack_release_id", 64'(m_sq_id), 64'd1);

        // Simultaneous ack and grant, then ack to an idle requester
        step(4'b0000, 1'b0, 1'b0, 0, 1'b1);
        step(4'b0100, 1'b1, 1'b0, 0, 1'b0);
        step(4'b0100, 1'b1, 1'b1, 2, 1'b0);
        step(4'b0100, 1'b1, 1'b0, 0, 1'b0);
        step(4'b0100, 1'b1, 1'b0, 0, 1'b0);
        check_val("same_cycle_err", 64'(ack_err), 64'd0);
        step(4'b0000, 1'b1, 1'b1, 3, 1'b0);
        step(4'b0000, 1'b1, 1'b0, 0, 1'b0);
`ifdef RDMA_SQ_CREDIT_EN
        check_val("err_sticky", 64'(ack_err), 64'd1);
`else
        check_val("err_tied", 64'(ack_err), 64'd0);
`endif

        // Reset while a request is pending
        step(4'b1111, 1'b0, 1'b0, 0, 1'b0);
        step(4'b1111, 1'b0, 1'b0, 0, 1'b1);
        check_val("midrst_valid", 64'(m_sq_valid), 64'd0);
        check_val("midrst_err", 64'(ack_err), 64'd0);
        step(4'b1111, 1'b1, 1'b0, 0, 1'b0);
        check_val("post_rst_id", 64'(m_sq_id), 64'd0);

        // Randomised traffic
        for (int t = 0; t < 500; t++) begin
            step(N'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                 int'($urandom_range(0, N - 1)), ($urandom_range(0, 79) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
